// File: rtl/bp_be_pkg.sv
// Shared types for the backend dual-issue scheduler: queue entry layout,
// scheduler FSM states and a small lane-count helper.
package bp_be_pkg;

    localparam int unsigned sched_reg_addr_width_gp = 5;
    localparam int unsigned sched_payload_width_gp  = 64;

    typedef enum logic [0:0] {
        e_run   = 1'b0,
        e_drain = 1'b1
    } bp_be_sched_state_e;

    // One decoded instruction as held in the issue queue.
    // rs_v[0] qualifies rs1, rs_v[1] qualifies rs2.
    typedef struct packed {
        logic [sched_reg_addr_width_gp-1:0] rs1;
        logic [sched_reg_addr_width_gp-1:0] rs2;
        logic [1:0]                         rs_v;
        logic [sched_reg_addr_width_gp-1:0] rd;
        logic                               rd_w_v;
        logic                               long;
        logic                               fence;
        logic [sched_payload_width_gp-1:0]  payload;
    } bp_be_sched_entry_s;

    // Number of set bits in a two-lane valid vector.
    function automatic logic [1:0] bp_be_lane_cnt(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/bp_be_sched_scoreboard.sv
// Register-file-sized busy-bit vector for in-flight long-latency destinations.
// Two set ports (one per issue slot), one clear port, combinational lookups.
// Register x0 is never scored, so any lookup of x0 misses.
module bp_be_sched_scoreboard #(
    parameter int unsigned reg_addr_width_p = 5,
    parameter int unsigned num_set_p        = 2,
    parameter int unsigned num_rd_p         = 6
) (
    input  logic                                        clk_i,
    input  logic                                        reset_n_i,
    input  logic [num_set_p-1:0]                        set_v_i,
    input  logic [num_set_p-1:0][reg_addr_width_p-1:0]  set_rd_i,
    input  logic                                        clear_v_i,
    input  logic [reg_addr_width_p-1:0]                 clear_rd_i,
    input  logic [num_rd_p-1:0][reg_addr_width_p-1:0]   rd_addr_i,
    output logic [num_rd_p-1:0]                         rd_hit_o,
    output logic                                        empty_o
);

    localparam int unsigned els_lp = 1 << reg_addr_width_p;
    localparam logic [els_lp-1:0] x0_mask_lp = ~(els_lp'(1));

    logic [els_lp-1:0] sb_q, sb_d;
    logic [els_lp-1:0] set_vec, clr_vec;

    // Decode set/clear requests; set is applied after clear so it wins on the same bit.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int i = 0; i < num_set_p; i++) begin
            if (set_v_i[i]) set_vec[set_rd_i[i]] = 1'b1;
        end
        if (clear_v_i) clr_vec[clear_rd_i] = 1'b1;
        sb_d = ((sb_q & ~clr_vec) | set_vec) & x0_mask_lp;
    end

    // Busy-bit register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) sb_q <= '0;
        else            sb_q <= sb_d;
    end

    // Lookups see the registered vector only; a clear shows up next cycle.
    always_comb begin
        for (int i = 0; i < num_rd_p; i++) rd_hit_o[i] = sb_q[rd_addr_i[i]];
    end

    assign empty_o = ~|sb_q;

endmodule

// File: rtl/bp_be_dual_issue_sched.sv
// In-order dual-issue scheduler: a small circular issue queue feeding two
// backend slots (slot 0 older). Issue selection is purely a function of the
// registered queue head and registered scoreboard. Fences drain the scoreboard
// and then issue alone.
module bp_be_dual_issue_sched
    import bp_be_pkg::*;
#(
    parameter int unsigned queue_els_p      = 4,
    parameter int unsigned payload_width_p  = sched_payload_width_gp,
    parameter int unsigned reg_addr_width_p = sched_reg_addr_width_gp
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic                                  flush_i,
    input  logic [1:0]                            enq_v_i,
    output logic                                  enq_ready_o,
    input  logic [1:0][reg_addr_width_p-1:0]      enq_rs1_i,
    input  logic [1:0][reg_addr_width_p-1:0]      enq_rs2_i,
    input  logic [1:0][1:0]                       enq_rs_v_i,
    input  logic [1:0][reg_addr_width_p-1:0]      enq_rd_i,
    input  logic [1:0]                            enq_rd_w_v_i,
    input  logic [1:0]                            enq_long_i,
    input  logic [1:0]                            enq_fence_i,
    input  logic [1:0][payload_width_p-1:0]       enq_payload_i,
    input  logic                                  iss_ready_i,
    output logic [1:0]                            iss_v_o,
    output logic [1:0][payload_width_p-1:0]       iss_payload_o,
    input  logic                                  clear_v_i,
    input  logic [reg_addr_width_p-1:0]           clear_rd_i,
    output logic                                  sb_empty_o,
    output logic [$clog2(queue_els_p+1)-1:0]      count_o
);

    localparam int unsigned ptr_w_lp = $clog2(queue_els_p);
    localparam int unsigned cnt_w_lp = $clog2(queue_els_p + 1);

    logic [ptr_w_lp-1:0] head_q, head_d, tail_q, tail_d;
    logic [ptr_w_lp-1:0] head_p1, tail_p1;
    logic [cnt_w_lp-1:0] cnt_q, cnt_d;
    bp_be_sched_state_e  state_q, state_d;
    bp_be_sched_entry_s  mem_q [queue_els_p];
    bp_be_sched_entry_s  mem_d [queue_els_p];
    bp_be_sched_entry_s  enq_e [2];
    bp_be_sched_entry_s  e0, e1;

    logic [5:0][reg_addr_width_p-1:0] sb_addr;
    logic [5:0]                       sb_hit;
    logic                             sb_empty;
    logic [1:0]                       sb_set_v;
    logic [1:0][reg_addr_width_p-1:0] sb_set_rd;

    logic       present0, present1, sb_ok0, sb_ok1, wr0, raw01, waw01;
    logic       elig0, elig1;
    logic [1:0] iss_v, fire;
    logic       enq_fire;
    logic [1:0] n_enq, n_deq;

    assign head_p1 = head_q + ptr_w_lp'(1);
    assign tail_p1 = tail_q + ptr_w_lp'(1);
    assign e0      = mem_q[head_q];
    assign e1      = mem_q[head_p1];

    // Pack the per-lane enqueue ports into queue entries.
    always_comb begin
        for (int l = 0; l < 2; l++) begin
            enq_e[l]         = '0;
            enq_e[l].rs1     = enq_rs1_i[l];
            enq_e[l].rs2     = enq_rs2_i[l];
            enq_e[l].rs_v    = enq_rs_v_i[l];
            enq_e[l].rd      = enq_rd_i[l];
            enq_e[l].rd_w_v  = enq_rd_w_v_i[l];
            enq_e[l].long    = enq_long_i[l];
            enq_e[l].fence   = enq_fence_i[l];
            enq_e[l].payload = enq_payload_i[l];
        end
    end

    assign sb_addr   = {e1.rd, e1.rs2, e1.rs1, e0.rd, e0.rs2, e0.rs1};
    assign sb_set_v  = fire & {e1.long & e1.rd_w_v, e0.long & e0.rd_w_v};
    assign sb_set_rd = {e1.rd, e0.rd};

    bp_be_sched_scoreboard #(
        .reg_addr_width_p (reg_addr_width_p),
        .num_set_p        (2),
        .num_rd_p         (6)
    ) u_sb (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .set_v_i    (sb_set_v),
        .set_rd_i   (sb_set_rd),
        .clear_v_i  (clear_v_i),
        .clear_rd_i (clear_rd_i),
        .rd_addr_i  (sb_addr),
        .rd_hit_o   (sb_hit),
        .empty_o    (sb_empty)
    );

    // Hazard checks on the two oldest entries; x0 never hits or matches.
    always_comb begin
        present0 = (cnt_q != '0);
        present1 = (cnt_q >= cnt_w_lp'(2));
        sb_ok0   = !(e0.rs_v[0] & sb_hit[0]) & !(e0.rs_v[1] & sb_hit[1]) & !(e0.rd_w_v & sb_hit[2]);
        sb_ok1   = !(e1.rs_v[0] & sb_hit[3]) & !(e1.rs_v[1] & sb_hit[4]) & !(e1.rd_w_v & sb_hit[5]);
        wr0      = e0.rd_w_v & (e0.rd != '0);
        raw01    = wr0 & ((e1.rs_v[0] & (e1.rs1 == e0.rd)) | (e1.rs_v[1] & (e1.rs2 == e0.rd)));
        waw01    = wr0 & e1.rd_w_v & (e1.rd == e0.rd);
        elig0    = present0 & sb_ok0 & !e0.fence;
        elig1    = elig0 & present1 & sb_ok1 & !raw01 & !waw01 & !(e0.long & e1.long) & !e1.fence;
    end

    // FSM next state and slot valids: run issues normally, drain holds a head
    // fence until the scoreboard is empty and then issues it alone.
    always_comb begin
        state_d = state_q;
        iss_v   = 2'b00;
        unique case (state_q)
            e_run: begin
                iss_v = {elig1, elig0};
                if (present0 && e0.fence) state_d = e_drain;
            end
            e_drain: begin
                iss_v = {1'b0, present0 & sb_empty};
                if (iss_v[0] && iss_ready_i) state_d = e_run;
            end
            default: state_d = e_run;
        endcase
        if (flush_i) state_d = e_run;
    end

    assign fire = iss_v & {2{iss_ready_i}};

    // Queue pointer/count update; flush empties the queue and beats enqueue.
    always_comb begin
        enq_fire = enq_ready_o & !flush_i;
        n_enq    = enq_fire ? bp_be_lane_cnt({enq_v_i[1] & enq_v_i[0], enq_v_i[0]}) : 2'd0;
        n_deq    = bp_be_lane_cnt(fire);
        head_d   = head_q + ptr_w_lp'(n_deq);
        tail_d   = tail_q + ptr_w_lp'(n_enq);
        cnt_d    = cnt_q + cnt_w_lp'(n_enq) - cnt_w_lp'(n_deq);
        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end
    end

    // Queue storage writes at the tail.
    always_comb begin
        mem_d = mem_q;
        if (enq_fire && enq_v_i[0])               mem_d[tail_q]  = enq_e[0];
        if (enq_fire && enq_v_i[0] && enq_v_i[1]) mem_d[tail_p1] = enq_e[1];
    end

    // Control state: pointers, occupancy and FSM.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            state_q <= e_run;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    // Queue payload storage; occupancy gates its use, so it needs no reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign enq_ready_o   = (cnt_q <= cnt_w_lp'(queue_els_p - 2));
    assign iss_v_o       = iss_v;
    assign iss_payload_o = {e1.payload, e0.payload};
    assign sb_empty_o    = sb_empty;
    assign count_o       = cnt_q;

endmodule

// File: tb/tb_bp_be_dual_issue_sched.sv
// Bench for the dual-issue scheduler: directed scenarios followed by random
// traffic, all checked against a queue/array reference model of the issue rules.
module tb_bp_be_dual_issue_sched;

    localparam int QE = 4;
    localparam int PW = 64;
    localparam int RW = 5;
    localparam int CW = $clog2(QE + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                   flush;
    logic [1:0]             enq_v;
    logic                   enq_ready;
    logic [1:0][RW-1:0]     enq_rs1, enq_rs2, enq_rd;
    logic [1:0][1:0]        enq_rs_v;
    logic [1:0]             enq_rd_w_v, enq_long, enq_fence;
    logic [1:0][PW-1:0]     enq_payload;
    logic                   iss_ready;
    logic [1:0]             iss_v;
    logic [1:0][PW-1:0]     iss_payload;
    logic                   clear_v;
    logic [RW-1:0]          clear_rd;
    logic                   sb_empty;
    logic [CW-1:0]          count;

    bp_be_dual_issue_sched #(.queue_els_p(QE), .payload_width_p(PW), .reg_addr_width_p(RW)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .flush_i(flush),
        .enq_v_i(enq_v), .enq_ready_o(enq_ready),
        .enq_rs1_i(enq_rs1), .enq_rs2_i(enq_rs2), .enq_rs_v_i(enq_rs_v),
        .enq_rd_i(enq_rd), .enq_rd_w_v_i(enq_rd_w_v), .enq_long_i(enq_long),
        .enq_fence_i(enq_fence), .enq_payload_i(enq_payload),
        .iss_ready_i(iss_ready), .iss_v_o(iss_v), .iss_payload_o(iss_payload),
        .clear_v_i(clear_v), .clear_rd_i(clear_rd),
        .sb_empty_o(sb_empty), .count_o(count)
    );

    typedef struct {
        logic [RW-1:0] rs1, rs2, rd;
        logic [1:0]    rs_v;
        logic          wr, lng, fence;
        logic [PW-1:0] pl;
    } ins_t;

    ins_t  mq[$];
    bit    sbm[32];
    bit    drain_m;
    ins_t  lane_e[2];
    int    n_chk = 0;
    int    n_err = 0;
    int    seq = 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit sb_none();
        foreach (sbm[i]) if (sbm[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit busy(input logic [RW-1:0] r);
        return (r != 0) && sbm[r];
    endfunction

    // An instruction is blocked if any used source or its written dest is in flight.
    function automatic bit blocked(input ins_t e);
        return (e.rs_v[0] && busy(e.rs1)) || (e.rs_v[1] && busy(e.rs2)) || (e.wr && busy(e.rd));
    endfunction

    function automatic logic [1:0] exp_iss();
        ins_t a, b;
        bit dep;
        if (drain_m) return (mq.size() > 0 && sb_none()) ? 2'b01 : 2'b00;
        if (mq.size() == 0) return 2'b00;
        a = mq[0];
        if (a.fence || blocked(a)) return 2'b00;
        if (mq.size() < 2) return 2'b01;
        b = mq[1];
        dep = a.wr && a.rd != 0 &&
              ((b.rs_v[0] && b.rs1 == a.rd) || (b.rs_v[1] && b.rs2 == a.rd) || (b.wr && b.rd == a.rd));
        if (blocked(b) || b.fence || (a.lng && b.lng) || dep) return 2'b01;
        return 2'b11;
    endfunction

    function automatic ins_t mk(input int rd, input int rs1, input int rs2, input logic [1:0] rs_v,
                                input bit wr, input bit lng, input bit fence);
        ins_t e;
        e.rd = RW'(rd); e.rs1 = RW'(rs1); e.rs2 = RW'(rs2); e.rs_v = rs_v;
        e.wr = wr; e.lng = lng; e.fence = fence;
        e.pl = {32'(seq), $urandom()};
        seq++;
        return e;
    endfunction

    task automatic set_lane(input int l, input ins_t e);
        lane_e[l]      = e;
        enq_v[l]       = 1'b1;
        enq_rs1[l]     = e.rs1;
        enq_rs2[l]     = e.rs2;
        enq_rs_v[l]    = e.rs_v;
        enq_rd[l]      = e.rd;
        enq_rd_w_v[l]  = e.wr;
        enq_long[l]    = e.lng;
        enq_fence[l]   = e.fence;
        enq_payload[l] = e.pl;
    endtask

    task automatic clr_in();
        enq_v = 2'b00; enq_rs1 = '0; enq_rs2 = '0; enq_rs_v = '0; enq_rd = '0;
        enq_rd_w_v = '0; enq_long = '0; enq_fence = '0; enq_payload = '0;
        flush = 1'b0; clear_v = 1'b0; clear_rd = '0;
    endtask

    task automatic model_reset();
        mq.delete();
        foreach (sbm[i]) sbm[i] = 1'b0;
        drain_m = 1'b0;
    endtask

    // Called at a falling edge with inputs applied: check outputs, advance the model
    // by one clock, and return at the next falling edge.
    task automatic cycle();
        logic [1:0] ev, fire;
        bit rdy, fence_head;
        int setl[$];
        ins_t e;
        #1;
        ev  = exp_iss();
        rdy = (QE - mq.size()) >= 2;
        chk("iss_v", 64'(iss_v), 64'(ev));
        chk("count", 64'(count), 64'(mq.size()));
        chk("enq_ready", 64'(enq_ready), 64'(rdy));
        chk("sb_empty", 64'(sb_empty), 64'(sb_none()));
        if (ev[0]) chk("payload0", iss_payload[0], mq[0].pl);
        if (ev[1]) chk("payload1", iss_payload[1], mq[1].pl);
        if (enq_v != 2'b00 && !flush) chk("enq_legal", 64'(enq_ready), 64'd1);

        fence_head = !drain_m && mq.size() > 0 && mq[0].fence;
        fire = ev & {2{iss_ready}};
        for (int s = 0; s < 2; s++) begin
            if (fire[s]) begin
                e = mq.pop_front();
                if (e.lng && e.wr && e.rd != 0) setl.push_back(int'(e.rd));
            end
        end
        if (clear_v && clear_rd != 0) sbm[clear_rd] = 1'b0;
        foreach (setl[i]) sbm[setl[i]] = 1'b1;
        if (flush) begin
            mq.delete();
            drain_m = 1'b0;
        end else begin
            if (rdy && enq_v[0]) mq.push_back(lane_e[0]);
            if (rdy && enq_v[0] && enq_v[1]) mq.push_back(lane_e[1]);
            if (fence_head) drain_m = 1'b1;
            else if (drain_m && fire[0]) drain_m = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        int r;
        clr_in();
        iss_ready = 1'b1;
        model_reset();
        #12;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_sb_empty", 64'(sb_empty), 64'd1);
        chk("rst_iss_v", 64'(iss_v), 64'd0);
        chk("rst_enq_ready", 64'(enq_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Independent pair issues together.
        set_lane(0, mk(1, 2, 3, 2'b11, 1, 0, 0));
        set_lane(1, mk(4, 5, 6, 2'b11, 1, 0, 0));
        cycle();
        clr_in();
        chk("pair_v", 64'(iss_v), 64'b11);
        cycle();
        chk("pair_count", 64'(count), 64'd0);

        // Intra-pair RAW splits the pair.
        set_lane(0, mk(1, 2, 3, 2'b11, 1, 0, 0));
        set_lane(1, mk(4, 1, 5, 2'b11, 1, 0, 0));
        cycle();
        clr_in();
        chk("raw_v1", 64'(iss_v), 64'b01);
        cycle();
        chk("raw_v2", 64'(iss_v), 64'b01);
        cycle();

        // Long-latency load then dependent add stalls until the clear.
        set_lane(0, mk(7, 0, 0, 2'b00, 1, 1, 0));
        set_lane(1, mk(8, 7, 0, 2'b11, 1, 0, 0));
        cycle();
        clr_in();
        cycle();
        chk("long_stall", 64'(iss_v), 64'b00);
        chk("long_sb", 64'(sb_empty), 64'd0);
        cycle();
        clear_v = 1'b1; clear_rd = 5'd7;
        cycle();
        clr_in();
        chk("long_release", 64'(iss_v), 64'b01);
        cycle();

        // Fence waits for the scoreboard to drain, then issues alone.
        set_lane(0, mk(9, 0, 0, 2'b00, 1, 1, 0));
        cycle();
        clr_in();
        cycle();
        set_lane(0, mk(0, 0, 0, 2'b00, 0, 0, 1));
        set_lane(1, mk(3, 1, 2, 2'b11, 1, 0, 0));
        cycle();
        clr_in();
        cycle();
        chk("fence_hold", 64'(iss_v), 64'b00);
        cycle();
        clear_v = 1'b1; clear_rd = 5'd9;
        cycle();
        clr_in();
        chk("fence_go", 64'(iss_v), 64'b01);
        cycle();
        chk("fence_after", 64'(iss_v), 64'b01);
        cycle();

        // Fill to four, then drain across the pointer wrap.
        set_lane(0, mk(10, 0, 0, 2'b00, 1, 1, 0));
        cycle();
        clr_in();
        cycle();
        iss_ready = 1'b0;
        set_lane(0, mk(11, 20, 21, 2'b11, 1, 0, 0));
        set_lane(1, mk(12, 20, 21, 2'b11, 1, 0, 0));
        cycle();
        chk("fill2_ready", 64'(enq_ready), 64'd1);
        set_lane(0, mk(13, 20, 21, 2'b11, 1, 0, 0));
        set_lane(1, mk(14, 20, 21, 2'b11, 1, 0, 0));
        cycle();
        clr_in();
        chk("fill4_count", 64'(count), 64'd4);
        chk("fill4_ready", 64'(enq_ready), 64'd0);
        iss_ready = 1'b1;
        cycle();
        cycle();
        chk("drain_count", 64'(count), 64'd0);

        // Flush with three entries keeps the scoreboard.
        iss_ready = 1'b0;
        set_lane(0, mk(15, 1, 2, 2'b11, 1, 0, 0));
        set_lane(1, mk(16, 1, 2, 2'b11, 1, 0, 0));
        cycle();
        clr_in();
        set_lane(0, mk(17, 1, 2, 2'b11, 1, 0, 0));
        cycle();
        clr_in();
        chk("pre_flush_count", 64'(count), 64'd3);
        flush = 1'b1;
        cycle();
        clr_in();
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_sb", 64'(sb_empty), 64'd0);
        iss_ready = 1'b1;
        clear_v = 1'b1; clear_rd = 5'd10;
        cycle();
        clr_in();

        // Same-cycle set and clear of x5: set wins.
        set_lane(0, mk(5, 0, 0, 2'b00, 1, 1, 0));
        cycle();
        clr_in();
        clear_v = 1'b1; clear_rd = 5'd5;
        cycle();
        clr_in();
        chk("set_wins", 64'(sb_empty), 64'd0);
        set_lane(0, mk(6, 5, 0, 2'b01, 1, 0, 0));
        cycle();
        clr_in();
        cycle();
        chk("stall_x5", 64'(iss_v), 64'b00);

        // Asynchronous reset in the middle of a stall.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_sb_empty", 64'(sb_empty), 64'd1);
        chk("arst_iss_v", 64'(iss_v), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            clr_in();
            iss_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 49) == 0);
            if (flush) iss_ready = 1'b0;
            if (!flush && (QE - mq.size()) >= 2) begin
                r = $urandom_range(0, 2);
                for (int l = 0; l < r; l++) begin
                    if ($urandom_range(0, 11) == 0)
                        set_lane(l, mk(0, 0, 0, 2'b00, 0, 0, 1));
                    else
                        set_lane(l, mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                                       2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                                       ($urandom_range(0, 2) == 0), 0));
                end
            end
            if ($urandom_range(0, 2) == 0) begin
                clear_v = 1'b1;
                clear_rd = RW'($urandom_range(0, 7));
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
